tpm_sync_controller: RTL and testbench

- Exchange sequencer that drives two `partner` tree-parity-machine instances (A and B) through neural key agreement.
- Generates the shared pseudo-random `feed` vector and the one-hot `ctrl` phases (compute, update, commit).
- Cross-couples each partner's `out` into the other's `out_other` and counts consecutive agreeing rounds to declare synchronisation or failure.
- Sits directly above the two partner instances, on the initiator side of their `feed`/`ctrl`/`out_other` interface.

---
 rtl/tpm_sync_if.sv | 30 +++
 rtl/tpm_sync_controller.sv | 135 +++++++++++++
 tb/tb_tpm_sync_controller.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tpm_sync_if.sv
// Handshake bundle between the key-exchange sequencer and its partners.
// The master side drives feed/ctrl/status; the slave side drives start/out bits.
interface tpm_sync_if #(
  parameter int FEED_W = 6,
  parameter int RND_W  = 10
);
  logic              start;
  logic              out_a;
  logic              out_b;
  logic [FEED_W-1:0] feed;
  logic [2:0]        ctrl;
  logic              out_other_a;
  logic              out_other_b;
  logic              busy;
  logic              synced;
  logic              fail;
  logic [RND_W-1:0]  round_cnt;

  modport master (
    input  start, out_a, out_b,
    output feed, ctrl, out_other_a, out_other_b,
    output busy, synced, fail, round_cnt
  );

  modport slave (
    output start, out_a, out_b,
    input  feed, ctrl, out_other_a, out_other_b,
    input  busy, synced, fail, round_cnt
  );
endinterface

// File: rtl/tpm_sync_controller.sv
// Sequencer for two tree-parity-machine partners: feed generation,
// phase control, output cross-coupling and agreement counting.
module tpm_sync_controller #(
  parameter int          FEED_W      = 6,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          COMPUTE_CYC = 6,
  parameter int          UPDATE_CYC  = 6,
  parameter int          SYNC_ROUNDS = 20,
  parameter int          MAX_ROUNDS  = 1000,
  parameter int          RND_W       = 10
) (
  input logic       clk,
  input logic       rst,
  tpm_sync_if.master bus
);

  localparam logic [15:0] SEED_V =
    (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam int AW = $clog2(SYNC_ROUNDS + 1);
  localparam logic [7:0] CMP_LAST = 8'(COMPUTE_CYC - 1);
  localparam logic [7:0] UPD_LAST = 8'(UPDATE_CYC - 1);
  localparam logic [AW-1:0] SYNC_N = AW'(SYNC_ROUNDS);
  localparam logic [RND_W-1:0] MAX_N = RND_W'(MAX_ROUNDS);

  typedef enum logic [2:0] {
    IDLE, GEN, COMPUTE, COMPARE, UPDATE, COMMIT, DONE
  } state_t;

  state_t          state;
  logic [15:0]     lfsr;
  logic [7:0]      cnt;
  logic [AW-1:0]   agree_cnt;

  logic [15:0]     lfsr_nxt;
  logic            agree;
  logic [AW-1:0]   agree_inc;
  logic [RND_W-1:0] rnd_inc;

  assign lfsr_nxt  = {lfsr[14:0],
                      lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign agree     = (bus.out_a == bus.out_b);
  assign agree_inc = agree_cnt + 1'b1;
  assign rnd_inc   = bus.round_cnt + 1'b1;

  // Exchange FSM; every output is a register updated on the transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      lfsr            <= SEED_V;
      cnt             <= '0;
      agree_cnt       <= '0;
      bus.feed        <= '0;
      bus.ctrl        <= 3'b000;
      bus.out_other_a <= 1'b0;
      bus.out_other_b <= 1'b0;
      bus.busy        <= 1'b0;
      bus.synced      <= 1'b0;
      bus.fail        <= 1'b0;
      bus.round_cnt   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state         <= GEN;
            bus.busy      <= 1'b1;
            bus.synced    <= 1'b0;
            bus.fail      <= 1'b0;
            bus.round_cnt <= '0;
            agree_cnt     <= '0;
            lfsr          <= SEED_V;
          end
        end
        GEN: begin
          bus.feed <= lfsr[FEED_W-1:0];
          lfsr     <= lfsr_nxt;
          bus.ctrl <= 3'b001;
          cnt      <= '0;
          state    <= COMPUTE;
        end
        COMPUTE: begin
          if (cnt == CMP_LAST) begin
            bus.ctrl <= 3'b000;
            state    <= COMPARE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMPARE: begin
          bus.out_other_a <= bus.out_b;
          bus.out_other_b <= bus.out_a;
          bus.round_cnt   <= rnd_inc;
          if (agree) begin
            agree_cnt <= agree_inc;
            if (agree_inc == SYNC_N) begin
              state      <= DONE;
              bus.busy   <= 1'b0;
              bus.synced <= 1'b1;
            end else if (rnd_inc == MAX_N) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.fail <= 1'b1;
            end else begin
              state    <= UPDATE;
              bus.ctrl <= 3'b010;
              cnt      <= '0;
            end
          end else begin
            agree_cnt <= '0;
            if (rnd_inc == MAX_N) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.fail <= 1'b1;
            end else begin
              state <= GEN;
            end
          end
        end
        UPDATE: begin
          if (cnt == UPD_LAST) begin
            bus.ctrl <= 3'b100;
            state    <= COMMIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          bus.ctrl <= 3'b000;
          state    <= GEN;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_sync_controller.sv
// Bench for tpm_sync_controller: a per-exchange timeline model built from
// round lengths and the LFSR rule, compared against the DUT every cycle.
module tb_tpm_sync_controller;

  localparam int SYNC = 4;
  localparam int MAXR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tpm_sync_if #(.FEED_W(6), .RND_W(10)) bus ();

  tpm_sync_controller #(
    .FEED_W(6), .SEED(16'hACE1), .COMPUTE_CYC(6), .UPDATE_CYC(6),
    .SYNC_ROUNDS(SYNC), .MAX_ROUNDS(MAXR), .RND_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    bit       start;
    bit       a;
    bit       b;
    bit [2:0] ctrl;
    bit [5:0] feed;
    bit       busy;
    bit       synced;
    bit       fail;
    bit [9:0] rc;
    bit       ooa;
    bit       oob;
  } step_t;

  step_t plan[$];
  step_t exp;
  bit    chk_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  bit [5:0] m_feed = '0;
  bit       m_ooa  = 1'b0;
  bit       m_oob  = 1'b0;

  bit [5:0] bf;
  bit       booa, boob, bbusy, bsyn, bfail;
  bit [9:0] brc;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input bit st, input bit a,
                               input bit b, input bit [2:0] c);
    step_t s;
    s.start = st; s.a = a; s.b = b; s.ctrl = c; s.feed = bf;
    s.busy = bbusy; s.synced = bsyn; s.fail = bfail; s.rc = brc;
    s.ooa = booa; s.oob = boob;
    plan.push_back(s);
  endfunction

  // Expected timeline of one exchange. pa/pb bit r = partner outputs
  // presented at the compare of round r+1; all other cycles get noise.
  function automatic void build(input bit [15:0] pa, input bit [15:0] pb);
    logic [15:0] lf;
    int ag, r;
    bit done, agr;
    plan.delete();
    lf = 16'hACE1;
    bf = m_feed; booa = m_ooa; boob = m_oob;
    brc = '0; bbusy = 1'b1; bsyn = 1'b0; bfail = 1'b0;
    push(1'b1, rb(), rb(), 3'b000);
    ag = 0; r = 0; done = 1'b0;
    while (!done) begin
      bf = lf[5:0];
      lf = lfsr_step(lf);
      repeat (6) push(1'b0, rb(), rb(), 3'b001);
      push(1'b0, rb(), rb(), 3'b000);
      agr = (pa[r] == pb[r]);
      brc++;
      booa = pb[r];
      boob = pa[r];
      ag = agr ? ag + 1 : 0;
      if (agr && ag == SYNC) begin
        bsyn = 1'b1; done = 1'b1;
      end else if (int'(brc) == MAXR) begin
        bfail = 1'b1; done = 1'b1;
      end
      if (done) begin
        bbusy = 1'b0;
        push(1'b0, pa[r], pb[r], 3'b000);
      end else if (agr) begin
        push(1'b0, pa[r], pb[r], 3'b010);
        repeat (5) push(1'b0, rb(), rb(), 3'b010);
        push(1'b0, rb(), rb(), 3'b100);
        push(1'b0, rb(), rb(), 3'b000);
      end else begin
        push(1'b0, pa[r], pb[r], 3'b000);
      end
      r++;
    end
    repeat (2) push(1'b0, rb(), rb(), 3'b000);
    m_feed = bf; m_ooa = booa; m_oob = boob;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < plan.size(); i++)
      if (plan[i].synced || plan[i].fail) return i;
    return -1;
  endfunction

  task automatic run(input int lo, input int hi);
    for (int s = lo; s <= hi && s < plan.size(); s++) begin
      bus.start = plan[s].start;
      bus.out_a = plan[s].a;
      bus.out_b = plan[s].b;
      @(posedge clk);
      #1;
      exp = plan[s];
      chk_en = 1'b1;
      bus.start = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      exp = '0;
      chk_en = 1'b1;
    end
    rst = 1'b0;
    m_feed = '0; m_ooa = 1'b0; m_oob = 1'b0;
  endtask

  // Cycle-by-cycle comparison against the model timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl", 32'(bus.ctrl), 32'(exp.ctrl));
      chk("feed", 32'(bus.feed), 32'(exp.feed));
      chk("busy", 32'(bus.busy), 32'(exp.busy));
      chk("synced", 32'(bus.synced), 32'(exp.synced));
      chk("fail", 32'(bus.fail), 32'(exp.fail));
      chk("round_cnt", 32'(bus.round_cnt), 32'(exp.rc));
      chk("out_other_a", 32'(bus.out_other_a), 32'(exp.ooa));
      chk("out_other_b", 32'(bus.out_other_b), 32'(exp.oob));
    end
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.out_a = 1'b0;
    bus.out_b = 1'b0;
    exp = '0;
    do_reset(2);

    // LFSR feed values and full agreement
    build(16'hFFFF, 16'hFFFF);
    chk("model_feed1", 32'(plan[1].feed), 32'h21);
    chk("model_feed2", 32'(plan[16].feed), 32'h03);
    chk("model_sync_at", first_done(), 53);
    run(0, 1);
    chk("feed_round1", 32'(bus.feed), 32'h21);
    run(2, 16);
    chk("feed_round2", 32'(bus.feed), 32'h03);
    run(17, 53);
    chk("agree_synced", 32'(bus.synced), 32'd1);
    chk("agree_busy", 32'(bus.busy), 32'd0);
    chk("agree_rc", 32'(bus.round_cnt), 32'd4);
    run(54, plan.size() - 1);

    // Persistent disagreement to the round limit
    build(16'hFFFF, 16'h0000);
    chk("model_fail_at", first_done(), 64);
    run(0, 8);
    chk("dis_ooa", 32'(bus.out_other_a), 32'd0);
    chk("dis_oob", 32'(bus.out_other_b), 32'd1);
    run(9, plan.size() - 1);
    chk("dis_fail", 32'(bus.fail), 32'd1);
    chk("dis_synced", 32'(bus.synced), 32'd0);
    chk("dis_rc", 32'(bus.round_cnt), 32'd8);

    // Interleaved: round 4 disagrees, sync lands on the last round
    build(16'hFFFF, 16'hFFF7);
    chk("model_inter_at", first_done(), 106);
    run(0, plan.size() - 1);
    chk("inter_synced", 32'(bus.synced), 32'd1);
    chk("inter_fail", 32'(bus.fail), 32'd0);
    chk("inter_rc", 32'(bus.round_cnt), 32'd8);

    // start pulsed during COMPUTE is ignored
    build(16'hFFFF, 16'hFFFF);
    plan[3].start = 1'b1;
    run(0, plan.size() - 1);
    chk("busy_start_rc", 32'(bus.round_cnt), 32'd4);

    // rst and start together in DONE
    bus.start = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp = '0;
    bus.start = 1'b0;
    rst = 1'b0;
    m_feed = '0; m_ooa = 1'b0; m_oob = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("prio_busy", 32'(bus.busy), 32'd0);
    chk("prio_ctrl", 32'(bus.ctrl), 32'd0);

    // Reset in the middle of UPDATE, then a clean restart
    build(16'hFFFF, 16'hFFFF);
    run(0, 10);
    chk("mid_update_ctrl", 32'(bus.ctrl), 32'b010);
    do_reset(3);
    chk("rst_feed", 32'(bus.feed), 32'd0);
    chk("rst_rc", 32'(bus.round_cnt), 32'd0);
    build(16'hFFFF, 16'hFFFF);
    run(0, plan.size() - 1);
    chk("restart_synced", 32'(bus.synced), 32'd1);
    chk("restart_rc", 32'(bus.round_cnt), 32'd4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
